// File: rtl/rom_arbiter.sv
// Shares the single-port instruction ROM between the fetch port and the data-load port.
// Define ROM_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed data-over-fetch.
module rom_arbiter #(
    parameter int unsigned DEPTH = 10000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic        d_we,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        rom_enable,
    output logic [31:0] rom_address,
    output logic [31:0] rom_dataIn,
    output logic        rom_writeEnable,
    input  logic [31:0] rom_dataOut
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    localparam logic [31:0] Limit = 32'(DEPTH * 4);

    state_e      state_q, state_d;
    logic        owner_data_q;
    logic        err_pend_q;
    logic        rom_enable_q;
    logic [31:0] rom_address_q;
    logic        if_rvalid_q, d_rvalid_q;
    logic [31:0] if_rdata_q, d_rdata_q;
    logic        if_err_q, d_err_q;

    logic        prefer_data;
    logic        gnt_data, gnt_fetch;
    logic        err_now;
    logic [31:0] req_addr;

`ifdef ROM_ARB_ROUND_ROBIN_EN
    logic last_data_q;  // 0 after reset ("fetch last"), so data wins the first tie
    assign prefer_data = !last_data_q;
`else
    assign prefer_data = 1'b1;
`endif

    always_comb begin
        gnt_data  = 1'b0;
        gnt_fetch = 1'b0;
        if (state_q == StIdle) begin
            if (d_req && (!if_req || prefer_data)) begin
                gnt_data = 1'b1;
            end else if (if_req) begin
                gnt_fetch = 1'b1;
            end
        end
    end

    // Data reads ignore the byte offset; misaligned fetches are errors.
    always_comb begin
        if (gnt_data) begin
            err_now  = d_we || (d_addr >= Limit);
            req_addr = {d_addr[31:2], 2'b00};
        end else begin
            err_now  = (if_addr >= Limit) || (if_addr[1:0] != 2'b00);
            req_addr = if_addr;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (gnt_data || gnt_fetch) state_d = StIssue;
            StIssue: state_d = StWait;
            StWait:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            owner_data_q  <= 1'b0;
            err_pend_q    <= 1'b0;
            rom_enable_q  <= 1'b0;
            rom_address_q <= '0;
            if_rvalid_q   <= 1'b0;
            d_rvalid_q    <= 1'b0;
            if_rdata_q    <= '0;
            d_rdata_q     <= '0;
            if_err_q      <= 1'b0;
            d_err_q       <= 1'b0;
`ifdef ROM_ARB_ROUND_ROBIN_EN
            last_data_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            rom_enable_q <= 1'b0;
            if_rvalid_q  <= 1'b0;
            d_rvalid_q   <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (gnt_data || gnt_fetch) begin
                        owner_data_q <= gnt_data;
                        err_pend_q   <= err_now;
`ifdef ROM_ARB_ROUND_ROBIN_EN
                        last_data_q  <= gnt_data;
`endif
                        // Enable lands in the ISSUE cycle; address holds otherwise.
                        if (!err_now) begin
                            rom_enable_q  <= 1'b1;
                            rom_address_q <= req_addr;
                        end
                    end
                end
                StWait: begin
                    if (owner_data_q) begin
                        d_rvalid_q <= 1'b1;
                        d_rdata_q  <= err_pend_q ? 32'h0 : rom_dataOut;
                        d_err_q    <= err_pend_q;
                    end else begin
                        if_rvalid_q <= 1'b1;
                        if_rdata_q  <= err_pend_q ? 32'h0 : rom_dataOut;
                        if_err_q    <= err_pend_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign if_gnt          = gnt_fetch;
    assign d_gnt           = gnt_data;
    assign if_rvalid       = if_rvalid_q;
    assign if_rdata        = if_rdata_q;
    assign if_err          = if_err_q;
    assign d_rvalid        = d_rvalid_q;
    assign d_rdata         = d_rdata_q;
    assign d_err           = d_err_q;
    assign rom_enable      = rom_enable_q;
    assign rom_address     = rom_address_q;
    assign rom_dataIn      = 32'h0;
    assign rom_writeEnable = 1'b0;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed self-checking bench for rom_arbiter with a behavioural ROM model.
// Handles both arbitration builds via ROM_ARB_ROUND_ROBIN_EN.
module tb_rom_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr;
    logic        if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err;
    logic [31:0] if_rdata, d_rdata;
    logic        rom_enable, rom_writeEnable;
    logic [31:0] rom_address, rom_dataIn, rom_dataOut;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rom_arbiter #(.DEPTH(10000)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .if_req          (if_req),
        .if_addr         (if_addr),
        .if_gnt          (if_gnt),
        .if_rvalid       (if_rvalid),
        .if_rdata        (if_rdata),
        .if_err          (if_err),
        .d_req           (d_req),
        .d_addr          (d_addr),
        .d_we            (d_we),
        .d_gnt           (d_gnt),
        .d_rvalid        (d_rvalid),
        .d_rdata         (d_rdata),
        .d_err           (d_err),
        .rom_enable      (rom_enable),
        .rom_address     (rom_address),
        .rom_dataIn      (rom_dataIn),
        .rom_writeEnable (rom_writeEnable),
        .rom_dataOut     (rom_dataOut)
    );

    // Word 4 holds 0xDEADBEEF; every other word is its index XOR 0x5A5A0000.
    function automatic logic [31:0] rom_word(input logic [29:0] idx);
        if (idx == 30'd4) return 32'hDEADBEEF;
        return {2'b00, idx} ^ 32'h5A5A_0000;
    endfunction

    always_ff @(posedge clk) begin
        if (rom_enable) rom_dataOut <= rom_word(rom_address[31:2]);
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        if_req = 1'b0;
        d_req  = 1'b0;
        d_we   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_gnt"}, {30'd0, if_gnt, d_gnt}, 32'd0);
        check_eq({tag, "_rvalid"}, {30'd0, if_rvalid, d_rvalid}, 32'd0);
        check_eq({tag, "_err"}, {30'd0, if_err, d_err}, 32'd0);
        check_eq({tag, "_if_rdata"}, if_rdata, 32'd0);
        check_eq({tag, "_d_rdata"}, d_rdata, 32'd0);
        check_eq({tag, "_rom_en"}, {31'd0, rom_enable}, 32'd0);
        check_eq({tag, "_rom_addr"}, rom_address, 32'd0);
    endtask

    // One transaction: grant in cycle T, checks through T+4.
    task automatic do_access(input string tag, input bit is_data, input bit we,
                             input logic [31:0] addr, input bit exp_err,
                             input logic [31:0] exp_data);
        logic rv;
        @(negedge clk);
        if (is_data) begin
            d_req = 1'b1; d_addr = addr; d_we = we;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        #1;
        check_eq({tag, "_gnt"}, {31'd0, is_data ? d_gnt : if_gnt}, 32'd1);
        check_eq({tag, "_other_gnt"}, {31'd0, is_data ? if_gnt : d_gnt}, 32'd0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            idle_inputs();
            #1;
            check_eq({tag, "_rom_en"}, {31'd0, rom_enable}, {31'd0, (c == 1) && !exp_err});
            if (c == 1 && !exp_err)
                check_eq({tag, "_rom_word"}, {2'b00, rom_address[31:2]}, {2'b00, addr[31:2]});
            check_eq({tag, "_late_gnt"}, {30'd0, if_gnt, d_gnt}, 32'd0);
            rv = is_data ? d_rvalid : if_rvalid;
            check_eq({tag, "_rvalid"}, {31'd0, rv}, {31'd0, c == 3});
            if (c == 3) begin
                check_eq({tag, "_rdata"}, is_data ? d_rdata : if_rdata, exp_data);
                check_eq({tag, "_err"}, {31'd0, is_data ? d_err : if_err}, {31'd0, exp_err});
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        if_addr = '0;
        d_addr  = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_all_zero("reset");
        check_eq("rom_dataIn", rom_dataIn, 32'd0);
        check_eq("rom_we", {31'd0, rom_writeEnable}, 32'd0);
        reset_n = 1'b1;

        do_access("fetch10", 1'b0, 1'b0, 32'h10, 1'b0, 32'hDEADBEEF);
        do_access("dwrite", 1'b1, 1'b1, 32'h20, 1'b1, 32'h0);
        do_access("fetch_oor", 1'b0, 1'b0, 32'h9C40, 1'b1, 32'h0);
        do_access("fetch_last", 1'b0, 1'b0, 32'h9C3C, 1'b0, 32'h5A5A270F);
        do_access("fetch_mis", 1'b0, 1'b0, 32'h12, 1'b1, 32'h0);
        do_access("dread13", 1'b1, 1'b0, 32'h13, 1'b0, 32'hDEADBEEF);
        do_access("dread_oor", 1'b1, 1'b0, 32'h9C40, 1'b1, 32'h0);

        // Retention: fetch result survives five data reads.
        do_access("ret_fetch", 1'b0, 1'b0, 32'h10, 1'b0, 32'hDEADBEEF);
        for (int k = 0; k < 5; k++) begin
            do_access("ret_dread", 1'b1, 1'b0, 32'h40 + 32'(k * 4), 1'b0,
                      32'h5A5A0010 + 32'(k));
            check_eq("ret_if_rdata", if_rdata, 32'hDEADBEEF);
        end

        // Reset asserted during WAIT drops the transaction.
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h10;
        #1;
        check_eq("rst_gnt", {31'd0, if_gnt}, 32'd1);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_all_zero("rst_wait");
        @(negedge clk);
        #1;
        check_eq("rst_no_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
        do_access("post_rst", 1'b0, 1'b0, 32'h10, 1'b0, 32'hDEADBEEF);

        // Both requests held from a fresh reset.
        do_reset();
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h10;
        d_req  = 1'b1; d_addr  = 32'h20;
        for (int c = 0; c < 12; c++) begin
            logic exp_d, exp_f;
            if (c > 0) @(negedge clk);
            #1;
            exp_d = 1'b0;
            exp_f = 1'b0;
            if (c % 3 == 0) begin
`ifdef ROM_ARB_ROUND_ROBIN_EN
                exp_d = ((c / 3) % 2 == 0);
`else
                exp_d = 1'b1;
`endif
                exp_f = !exp_d;
            end
            check_eq("arb_d_gnt", {31'd0, d_gnt}, {31'd0, exp_d});
            check_eq("arb_if_gnt", {31'd0, if_gnt}, {31'd0, exp_f});
            if (c == 3) check_eq("arb_d_rvalid", {31'd0, d_rvalid}, 32'd1);
        end
        @(negedge clk);
        d_req = 1'b0;
        #1;
        check_eq("arb_release_if_gnt", {31'd0, if_gnt}, 32'd1);
        check_eq("arb_release_d_gnt", {31'd0, d_gnt}, 32'd0);
        @(negedge clk);
        idle_inputs();
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Read-port arbiter sharing the single-port instruction ROM between the riscado-v core's instruction-fetch port and its data-load port. Accepts one request at a time through a req/gnt handshake, issues a one-cycle ROM read, and returns the word with a one-cycle response strobe to the requester that owns it. Write attempts and out-of-range or misaligned accesses are rejected with an error response, and the ROM is never accessed for them. Sits between the core's bus ports and the ROM instance in the SoC top level.

## Interface
- DEPTH, 10000: ROM depth in 32-bit words. Byte addresses ≥ DEPTH*4 are out of range.
- clk  in  1  system clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  32  fetch byte address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  one-cycle fetch response strobe
- if_rdata  out  32  fetch read data, held until the next fetch response
- if_err  out  1  fetch error flag, valid with if_rvalid
- d_req  in  1  data request; held until d_gnt
- d_addr  in  32  data byte address
- d_we  in  1  data write attempt (always rejected)
- d_gnt, d_rvalid, d_rdata[31:0], d_err  out  data-port counterparts of the if_* outputs
- rom_enable  out  1  ROM read enable
- rom_address  out  32  ROM byte address (the ROM uses bits [31:2])
- rom_dataIn  out  32  tied to 0
- rom_writeEnable  out  1  tied to 0
- rom_dataOut  in  32  ROM read data, valid the cycle after rom_enable

## Operation
- FSM states:
  - IDLE: if any req is high, arbitrate, pulse the winner's gnt combinationally, latch addr, port and err_pending, then go to ISSUE.
  - ISSUE: rom_enable=1 unless err_pending; go to WAIT.
  - WAIT: capture rom_dataOut (or 0 if err_pending) into the owner's rdata/err registers, set the owner's rvalid for the next cycle, then go to IDLE.
- err_pending is set by any of: d_we=1; addr ≥ DEPTH*4; fetch addr[1:0]≠0.
  - Data reads ignore addr[1:0] and return the aligned word.
- Only one gnt is high per cycle, and only in IDLE. A req seen outside IDLE is not acknowledged until the next IDLE.
- rom_enable and rom_address are registered. rom_address holds its last value when rom_enable=0.
- rvalid and a new gnt may coincide in the same IDLE cycle.
- Reset (any state): state←IDLE; all outputs 0; rdata registers 0; arbitration pointer←"fetch last".
  - An in-flight transaction is dropped and no rvalid is issued for it.

## Timing
- Request accepted (gnt high) in cycle T; rom_enable high in T+1 only; rom_dataOut sampled at the end of T+2; rvalid high in T+3 only.
- Peak throughput is one access per 3 cycles. A continuously held req is granted at T, T+3, T+6, …
- Outputs are glitch-free registers except if_gnt/d_gnt, which are combinational from state and req.

## Configuration
- ROM_ARB_ROUND_ROBIN_EN defined: round-robin arbitration.
  - On a tie, the port not granted last wins; the pointer updates on every grant.
  - After reset the data port wins the first tie.
- Undefined: fixed priority, data over fetch. A held d_req starves fetch indefinitely.

## Test plan
- Fetch only, if_addr=0x10, ROM word 4=0xDEADBEEF -> if_gnt at T; rom_enable=1 with rom_address=0x10 only in T+1; if_rvalid=1, if_rdata=0xDEADBEEF, if_err=0 only in T+3.
- if_req and d_req both held, macro defined -> grants alternate d,if,d,if at T, T+3, T+6, T+9. Macro undefined -> d_gnt at T, T+3, T+6, and if_gnt never asserts until d_req drops.
- d_req with d_we=1, d_addr=0x20 -> d_gnt at T; rom_enable stays 0 throughout; d_rvalid at T+3 with d_err=1, d_rdata=0.
- Fetch of if_addr=0x9C40 (DEPTH=10000) and of if_addr=0x12 -> each returns if_err=1, if_rdata=0, no rom_enable. d_addr=0x13 read -> returns word 4, d_err=0.
- reset_n=0 for one cycle during WAIT -> no rvalid follows; all outputs 0 the cycle after. A subsequent fetch completes with standard T+3 latency.
- if_rdata retention: fetch returns 0xDEADBEEF, then 5 data reads -> if_rdata remains 0xDEADBEEF throughout.
